// File: rtl/jk_bank_sequencer_if.sv
// Command channel of the JK bank sequencer: one command per valid/ready handshake,
// plus the abort strobe that may cut a running COUNT short.
interface jk_bank_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0] cmd_count;
  logic             cmd_abort;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_count, cmd_abort,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_count, cmd_abort,
    output cmd_ready
  );
endinterface

// File: rtl/jk_bank_sequencer.sv
// Command-driven controller for a bank of WIDTH external JK flip-flops: drives
// per-bit J/K and the shared enable for SET/CLEAR/TOGGLE/LOAD and multi-step COUNT.
module jk_bank_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  jk_bank_sequencer_if.slave   cmd,
  input  logic [WIDTH-1:0]     q_in,
  output logic                 jk_en,
  output logic [WIDTH-1:0]     j_out,
  output logic [WIDTH-1:0]     k_out,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_APPLY,
    S_COUNT,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP     = 3'b000,
    OP_SET     = 3'b001,
    OP_CLEAR   = 3'b010,
    OP_TOGGLE  = 3'b011,
    OP_LOAD    = 3'b100,
    OP_UP      = 3'b101,
    OP_DOWN    = 3'b110,
    OP_ILLEGAL = 3'b111
  } op_t;

  state_t           state, state_n;
  op_t              op;
  op_t              new_op;
  logic [WIDTH-1:0] data;
  logic [CNT_W-1:0] remaining;
  logic             accept;
  logic [WIDTH-1:0] carry_up, carry_down;

  assign cmd.cmd_ready = (state == S_IDLE) && reset;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign new_op        = op_t'(cmd.cmd_op);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; combinational blocks below use blocking assignments.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      op        <= OP_NOP;
      data      <= '0;
      remaining <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        op        <= new_op;
        data      <= cmd.cmd_data;
        remaining <= cmd.cmd_count;
      end else if (state == S_COUNT) begin
        remaining <= remaining - CNT_W'(1);
      end
    end
  end

  // Toggle masks for a ripple counter: bit i flips when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    logic all_one, all_zero;
    all_one    = 1'b1;
    all_zero   = 1'b1;
    carry_up   = '0;
    carry_down = '0;
    for (int i = 0; i < WIDTH; i++) begin
      carry_up[i]   = all_one;
      carry_down[i] = all_zero;
      all_one       = all_one & q_in[i];
      all_zero      = all_zero & ~q_in[i];
    end
  end

  // NOTE: every output and next-state term gets a default first, so no path
  // through the case statements can leave a latch behind.
  always_comb begin
    state_n = state;
    jk_en   = 1'b0;
    j_out   = '0;
    k_out   = '0;
    busy    = (state != S_IDLE);
    done    = (state == S_DONE);
    err     = (state == S_DONE) && (op == OP_ILLEGAL);

    case (state)
      S_IDLE: begin
        if (accept) begin
          case (new_op)
            OP_SET, OP_CLEAR, OP_TOGGLE, OP_LOAD: state_n = S_APPLY;
            OP_UP, OP_DOWN: state_n = (cmd.cmd_count != '0) ? S_COUNT : S_DONE;
            default:        state_n = S_DONE;
          endcase
        end
      end
      S_APPLY: begin
        state_n = S_DONE;
        jk_en   = reset;
        case (op)
          OP_SET:    j_out = '1;
          OP_CLEAR:  k_out = '1;
          OP_TOGGLE: begin j_out = data; k_out = data;  end
          OP_LOAD:   begin j_out = data; k_out = ~data; end
          default:   jk_en = 1'b0;
        endcase
      end
      S_COUNT: begin
        if (cmd.cmd_abort || remaining == CNT_W'(1)) state_n = S_DONE;
        // Reset low must keep the bank untouched even before the reset edge lands.
        jk_en = reset && !cmd.cmd_abort;
        j_out = (op == OP_UP) ? carry_up : carry_down;
        k_out = j_out;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    if (!jk_en) begin
      j_out = '0;
      k_out = '0;
    end
  end

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Self-checking bench: emulates a 4-bit JK bank on j_out/k_out/jk_en and checks
// directed scenarios plus random commands against an arithmetic model of each op.
module tb_jk_bank_sequencer;
  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  localparam logic [2:0] OP_NOP = 3'b000, OP_SET = 3'b001, OP_CLEAR = 3'b010,
                         OP_TOGGLE = 3'b011, OP_LOAD = 3'b100, OP_UP = 3'b101,
                         OP_DOWN = 3'b110, OP_ILL = 3'b111;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] q = '0;
  logic             jk_en, busy, done, err;
  logic [WIDTH-1:0] j_out, k_out;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  jk_bank_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  jk_bank_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .cmd   (bus),
    .q_in  (q),
    .jk_en (jk_en),
    .j_out (j_out),
    .k_out (k_out),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  // The external JK bank: hold / set / reset / toggle per cell when enabled.
  always @(posedge clk) begin
    if (jk_en) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (j_out[i] && k_out[i]) q[i] <= ~q[i];
        else if (j_out[i])        q[i] <= 1'b1;
        else if (k_out[i])        q[i] <= 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one command and let the accepting edge pass.
  task automatic issue(input logic [2:0] op, input logic [3:0] d, input logic [7:0] c);
    check("issue_ready", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
    bus.cmd_count = c;
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'($urandom);
    bus.cmd_data  = 4'($urandom);
    bus.cmd_count = 8'($urandom);
  endtask

  function automatic logic [3:0] model_q(input logic [2:0] op, input logic [3:0] d,
                                         input logic [7:0] c, input logic [3:0] q0);
    case (op)
      OP_SET:    return 4'hF;
      OP_CLEAR:  return 4'h0;
      OP_TOGGLE: return q0 ^ d;
      OP_LOAD:   return d;
      OP_UP:     return q0 + c[3:0];
      OP_DOWN:   return q0 - c[3:0];
      default:   return q0;
    endcase
  endfunction

  function automatic int model_updates(input logic [2:0] op, input logic [7:0] c);
    if (op >= OP_SET && op <= OP_LOAD) return 1;
    if (op == OP_UP || op == OP_DOWN)  return int'(c);
    return 0;
  endfunction

  function automatic logic [7:0] model_jk(input logic [2:0] op, input logic [3:0] d,
                                          input logic [3:0] qc);
    logic [3:0] nxt;
    case (op)
      OP_SET:    return {4'hF, 4'h0};
      OP_CLEAR:  return {4'h0, 4'hF};
      OP_TOGGLE: return {d, d};
      OP_LOAD:   return {d, ~d};
      OP_UP:     begin nxt = qc + 4'd1; return {qc ^ nxt, qc ^ nxt}; end
      OP_DOWN:   begin nxt = qc - 4'd1; return {qc ^ nxt, qc ^ nxt}; end
      default:   return 8'h00;
    endcase
  endfunction

  // Full command run: bank updates, per-update J/K, latency to done, err, final Q.
  task automatic run_cmd(input logic [2:0] op, input logic [3:0] d, input logic [7:0] c);
    logic [3:0] exp_q;
    int         exp_n;
    int         updates;
    bit         seen;
    exp_q   = model_q(op, d, c, q);
    exp_n   = model_updates(op, c);
    updates = 0;
    seen    = 1'b0;
    issue(op, d, c);
    for (int n = 0; n < 300 && !seen; n++) begin
      if (done) begin
        seen = 1'b1;
        check("done_latency", n, exp_n);
        check("done_err", err, (op == OP_ILL) ? 1 : 0);
        check("done_jk_en", jk_en, 0);
        check("done_jk_zero", {j_out, k_out}, 0);
        check("final_q", q, exp_q);
      end else begin
        if (jk_en) begin
          updates++;
          check("jk_pattern", {j_out, k_out}, model_jk(op, d, q));
        end
        tick();
      end
    end
    check("done_seen", seen, 1);
    check("bank_updates", updates, exp_n);
    tick();
    check("ready_after", bus.cmd_ready, 1);
  endtask

  initial begin
    reset         = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_SET;
    bus.cmd_data  = '0;
    bus.cmd_count = '0;
    bus.cmd_abort = 1'b0;

    // Reset held for two edges with a SET pending.
    repeat (2) tick();
    check("rst_ready", bus.cmd_ready, 0);
    check("rst_jk_en", jk_en, 0);
    check("rst_jk", {j_out, k_out}, 0);
    check("rst_busy", busy, 0);
    check("rst_done_err", {done, err}, 0);
    check("rst_q", q, 4'h0);
    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    #1;
    check("release_ready", bus.cmd_ready, 1);

    // LOAD 1010, with an abort that must be ignored outside COUNT.
    bus.cmd_abort = 1'b1;
    issue(OP_LOAD, 4'b1010, 8'd0);
    check("load_jk_en", jk_en, 1);
    check("load_j", j_out, 4'b1010);
    check("load_k", k_out, 4'b0101);
    check("load_busy_ready", {busy, bus.cmd_ready}, 2'b10);
    check("load_no_done", done, 0);
    bus.cmd_abort = 1'b0;
    tick();
    check("load_q", q, 4'b1010);
    check("load_done", {done, err, jk_en}, 3'b100);
    check("load_ready_low", bus.cmd_ready, 0);
    tick();
    check("load_ready_back", bus.cmd_ready, 1);
    check("load_done_gone", done, 0);

    // COUNT UP 3 from 1110 wraps through 1111 -> 0000 -> 0001.
    run_cmd(OP_LOAD, 4'b1110, 8'd0);
    issue(OP_UP, 4'h0, 8'd3);
    check("up_en1", jk_en, 1);
    tick();
    check("up_q1", q, 4'b1111);
    check("up_en2", jk_en, 1);
    tick();
    check("up_q2", q, 4'b0000);
    check("up_en3", jk_en, 1);
    tick();
    check("up_q3", q, 4'b0001);
    check("up_done", {done, err, jk_en}, 3'b100);
    tick();

    // COUNT DOWN 2 from 0000 wraps to 1111 then 1110.
    run_cmd(OP_LOAD, 4'b0000, 8'd0);
    issue(OP_DOWN, 4'h0, 8'd2);
    tick();
    check("down_q1", q, 4'b1111);
    tick();
    check("down_q2", q, 4'b1110);
    check("down_done", done, 1);
    tick();

    // COUNT with zero steps: straight to done.
    issue(OP_UP, 4'h0, 8'd0);
    check("cnt0_done", {done, err, jk_en}, 3'b100);
    check("cnt0_q", q, 4'b1110);
    tick();
    check("cnt0_ready", bus.cmd_ready, 1);

    // Illegal opcode: done and err together, bank untouched.
    issue(OP_ILL, 4'hF, 8'd5);
    check("ill_done_err", {done, err, jk_en}, 3'b110);
    check("ill_q", q, 4'b1110);
    tick();
    check("ill_err_gone", {done, err}, 0);

    // TOGGLE 0101 on 1111.
    run_cmd(OP_SET, 4'h0, 8'd0);
    issue(OP_TOGGLE, 4'b0101, 8'd0);
    check("tog_jk", {j_out, k_out}, 8'b0101_0101);
    tick();
    check("tog_q", q, 4'b1010);
    check("tog_done", done, 1);
    tick();

    // Abort in the third COUNT cycle.
    run_cmd(OP_LOAD, 4'b0000, 8'd0);
    issue(OP_UP, 4'h0, 8'd10);
    tick();
    tick();
    bus.cmd_abort = 1'b1;
    #1;
    check("abort_jk_en", jk_en, 0);
    tick();
    bus.cmd_abort = 1'b0;
    check("abort_done", {done, err}, 2'b10);
    check("abort_q", q, 4'b0010);
    tick();
    check("abort_ready", bus.cmd_ready, 1);

    // Reset in the third COUNT cycle.
    run_cmd(OP_LOAD, 4'b0000, 8'd0);
    issue(OP_UP, 4'h0, 8'd10);
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("midrst_jk_en", jk_en, 0);
    check("midrst_ready", bus.cmd_ready, 0);
    tick();
    check("midrst_idle", {busy, done, jk_en}, 0);
    check("midrst_q", q, 4'b0010);
    reset = 1'b1;
    #1;
    check("midrst_ready_back", bus.cmd_ready, 1);

    // Random commands against the arithmetic model.
    for (int t = 0; t < 30; t++) begin
      run_cmd(3'($urandom), 4'($urandom), 8'($urandom_range(0, 12)));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
